chip_test_ctrl: RTL and testbench

Sequencer that sits directly upstream of the per-chip tester blocks and consumes their results. It debounces the user Start and Ack buttons, issues a one-cycle Run to the tester selected by the chip-select switches, and waits for that tester's Done, with a timeout. It then captures RSLT, holds Pass/Fail for the display, and on Ack pulses DISP_RSLT to return the tester to its halted state.

---
 rtl/chip_ctrl_pkg.sv | 10 +
 rtl/button_debounce.sv | 37 +++
 rtl/chip_test_ctrl.sv | 111 +++++++++++
 tb/tb_chip_test_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chip_ctrl_pkg.sv
// chip_ctrl_pkg: shared FSM state encoding, default sizes and select-width helper for chip_test_ctrl
package chip_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, ARM, WAIT_DONE, SETTLE, SHOW, RELEASE} ctrl_state_t;
    localparam int DEF_NUM_CHIPS      = 8;
    localparam int DEF_DEB_CYCLES     = 16;
    localparam int DEF_TIMEOUT_CYCLES = 1024;
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-flop synchronizer, stability counter, debounced level and one-cycle rising-edge pulse
module button_debounce import chip_ctrl_pkg::*; #(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic Clk,
    input  logic Reset,
    input  logic btn_i,
    output logic pulse_o
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    logic [1:0]    sync_q, vld_q;
    logic [CW-1:0] cnt_q;
    logic          lvl_q, armed_q, pulse_q;
    logic          s, hit;
    assign s       = sync_q[1];
    assign hit     = (s != lvl_q) && (cnt_q == CW'(DEB_CYCLES - 1));
    assign pulse_o = pulse_q;
    // Level follows the synchronized input only after DEB_CYCLES stable cycles; a press
    // only pulses once the button has been seen released, so a press held through reset is silent
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync_q  <= '0;
            vld_q   <= '0;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
            armed_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            vld_q   <= {vld_q[0], 1'b1};
            armed_q <= armed_q | (vld_q[1] & ~s);
            cnt_q   <= (s == lvl_q || hit) ? '0 : cnt_q + 1'b1;
            lvl_q   <= hit ? s : lvl_q;
            pulse_q <= hit & s & armed_q;
        end
    end
endmodule

// File: rtl/chip_test_ctrl.sv
// chip_test_ctrl: start/run/wait/show/release sequencer for per-chip testers; CHIP_TIMEOUT_EN enables the WAIT_DONE watchdog
module chip_test_ctrl import chip_ctrl_pkg::*; #(
    parameter int NUM_CHIPS      = DEF_NUM_CHIPS,
    parameter int DEB_CYCLES     = DEF_DEB_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                              Clk,
    input  logic                              Reset,
    input  logic                              Start_btn,
    input  logic                              Ack_btn,
    input  logic [sel_width(NUM_CHIPS)-1:0]   Chip_sel,
    input  logic [NUM_CHIPS-1:0]              Done_vec,
    input  logic [NUM_CHIPS-1:0]              RSLT_vec,
    output logic [NUM_CHIPS-1:0]              Run_vec,
    output logic                              DISP_RSLT,
    output logic                              Busy,
    output logic                              Result_valid,
    output logic                              Pass,
    output logic                              Fail,
    output logic                              Timeout
);
    localparam int SW = sel_width(NUM_CHIPS);
    if (NUM_CHIPS < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("chip_test_ctrl: NUM_CHIPS and TIMEOUT_CYCLES must be at least 2");
    end
    ctrl_state_t   state_q, state_d;
    logic [SW-1:0] sel_q, sel_d;
    logic          pass_q, pass_d, fail_q, fail_d;
    logic          start_p, ack_p, timeout_hit, sel_ok;
    button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_start (
        .Clk(Clk), .Reset(Reset), .btn_i(Start_btn), .pulse_o(start_p)
    );
    button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_ack (
        .Clk(Clk), .Reset(Reset), .btn_i(Ack_btn), .pulse_o(ack_p)
    );
    assign sel_ok = 32'(Chip_sel) < NUM_CHIPS;
`ifdef CHIP_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] cnt_q;
    logic          to_q;
    assign timeout_hit = (state_q == WAIT_DONE) && !Done_vec[sel_q] && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign Timeout     = to_q;
    // Wait counter restarts while idle and saturates; the timeout flag lives until RELEASE
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= (state_q == IDLE) ? '0 : (state_q == WAIT_DONE && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
            to_q  <= timeout_hit ? 1'b1 : (state_q == RELEASE) ? 1'b0 : to_q;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign Timeout     = 1'b0;
`endif
    // State, latched select and held result registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
        end
    end
    // Next-state and result update; Done has priority over the watchdog in the same cycle
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        case (state_q)
            IDLE: if (start_p) begin
                sel_d   = Chip_sel;
                state_d = sel_ok ? ARM : SHOW;
                pass_d  = 1'b0;
                fail_d  = !sel_ok;
            end
            ARM:       state_d = WAIT_DONE;
            WAIT_DONE: if (Done_vec[sel_q]) state_d = SETTLE;
                       else if (timeout_hit) begin
                           state_d = SHOW;
                           pass_d  = 1'b0;
                           fail_d  = 1'b1;
                       end
            SETTLE: begin
                pass_d  = RSLT_vec[sel_q];
                fail_d  = ~RSLT_vec[sel_q];
                state_d = SHOW;
            end
            SHOW:      state_d = ack_p ? RELEASE : SHOW;
            RELEASE: begin
                pass_d  = 1'b0;
                fail_d  = 1'b0;
                state_d = IDLE;
            end
            default:   state_d = IDLE;
        endcase
    end
    assign Run_vec      = (state_q == ARM) ? (NUM_CHIPS'(1) << sel_q) : '0;
    assign DISP_RSLT    = state_q == RELEASE;
    assign Busy         = !(state_q == IDLE || state_q == SHOW);
    assign Result_valid = state_q == SHOW;
    assign Pass         = pass_q;
    assign Fail         = fail_q;
endmodule

// File: tb/tb_chip_test_ctrl.sv
// tb_chip_test_ctrl: table-driven and scoreboard checks of chip_test_ctrl (8-chip and 6-chip instances)
module tb_chip_test_ctrl;
    typedef struct {
        logic [2:0] sel;
        logic       rslt;
        logic       glitch;
        logic       noise;
        logic       exp_pass;
        logic       exp_fail;
    } vec_t;
    typedef struct {
        logic p;
        logic f;
        logic t;
    } res_t;

    logic       Clk = 0, Reset = 1;
    logic       start8 = 0, ack8 = 0, start6 = 0, ack6 = 0;
    logic [2:0] sel8 = 0, sel6 = 0;
    logic [7:0] done8 = 0, rslt8 = 0, run8;
    logic [5:0] done6 = 0, rslt6 = 0, run6;
    logic       disp8, busy8, rv8, pass8, fail8, to8;
    logic       disp6, busy6, rv6, pass6, fail6, to6;
    int         errors = 0, checks = 0, runs8 = 0, runs6 = 0;
    res_t       q8[$], q6[$];
    logic       rv8_d = 0, rv6_d = 0;
    vec_t       tbl[4];

    chip_test_ctrl #(.NUM_CHIPS(8), .DEB_CYCLES(16), .TIMEOUT_CYCLES(1024)) u8 (
        .Clk(Clk), .Reset(Reset), .Start_btn(start8), .Ack_btn(ack8), .Chip_sel(sel8),
        .Done_vec(done8), .RSLT_vec(rslt8), .Run_vec(run8), .DISP_RSLT(disp8), .Busy(busy8),
        .Result_valid(rv8), .Pass(pass8), .Fail(fail8), .Timeout(to8)
    );
    chip_test_ctrl #(.NUM_CHIPS(6), .DEB_CYCLES(16), .TIMEOUT_CYCLES(32)) u6 (
        .Clk(Clk), .Reset(Reset), .Start_btn(start6), .Ack_btn(ack6), .Chip_sel(sel6),
        .Done_vec(done6), .RSLT_vec(rslt6), .Run_vec(run6), .DISP_RSLT(disp6), .Busy(busy6),
        .Result_valid(rv6), .Pass(pass6), .Fail(fail6), .Timeout(to6)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // 0: run8, 1: disp8, 2: run6, 3: disp6, 4: rv6
    task automatic wait_for(input int which, input int budget, output int n);
        bit hit;
        hit = 0;
        n = 0;
        while (!hit && n < budget) begin
            @(negedge Clk);
            n++;
            case (which)
                0: hit = run8 != 0;
                1: hit = disp8;
                2: hit = run6 != 0;
                3: hit = disp6;
                default: hit = rv6;
            endcase
        end
        if (!hit) chk($sformatf("wait_%0d_expired", which), 0, 1);
    endtask

    // Scoreboard: expected results popped on each rising Result_valid; run cycles counted
    always @(negedge Clk) begin
        if (run8 != 0) runs8++;
        if (run6 != 0) runs6++;
        if (rv8 && !rv8_d) begin
            if (q8.size() == 0) chk("sb8_unexpected_result", 1, 0);
            else begin
                res_t e;
                e = q8.pop_front();
                chk("sb8_pass", pass8, e.p);
                chk("sb8_fail", fail8, e.f);
                chk("sb8_timeout", to8, e.t);
            end
        end
        if (rv6 && !rv6_d) begin
            if (q6.size() == 0) chk("sb6_unexpected_result", 1, 0);
            else begin
                res_t e;
                e = q6.pop_front();
                chk("sb6_pass", pass6, e.p);
                chk("sb6_fail", fail6, e.f);
                chk("sb6_timeout", to6, e.t);
            end
        end
        rv8_d = rv8;
        rv6_d = rv6;
    end

    task automatic ack_release8();
        int n;
        ack8 = 1;
        wait_for(1, 60, n);
        chk("release_busy", busy8, 1);
        chk("release_rv", rv8, 0);
        cyc();
        @(negedge Clk);
        chk("disp_width", disp8, 0);
        chk("idle_busy", busy8, 0);
        chk("idle_rv", rv8, 0);
        chk("idle_pass", pass8, 0);
        chk("idle_fail", fail8, 0);
        ack8 = 0;
        cyc(30);
    endtask

    task automatic do_txn(input vec_t v);
        int n, r0;
        r0 = runs8;
        sel8 = v.sel;
        if (v.glitch) for (int i = 0; i < 10; i++) begin
            start8 = ~start8;
            cyc();
        end
        start8 = 1;
        wait_for(0, 60, n);
        chk("run_onehot", run8, 8'(1) << v.sel);
        chk("arm_busy", busy8, 1);
        cyc();
        start8 = 0;
        sel8 = ~v.sel;
        @(negedge Clk);
        chk("run_width", run8, 0);
        chk("wait_busy", busy8, 1);
        if (v.noise) begin
            ack8 = 1;
            for (int i = 0; i < 30; i++) begin
                done8[3] = ~done8[3];
                cyc();
            end
            ack8 = 0;
            for (int i = 0; i < 30; i++) begin
                done8[3] = ~done8[3];
                cyc();
            end
            done8[3] = 0;
            @(negedge Clk);
            chk("noise_rv", rv8, 0);
            chk("noise_busy", busy8, 1);
        end else cyc(25);
        cyc();
        done8[v.sel] = 1;
        rslt8[v.sel] = ~v.rslt;
        q8.push_back('{v.exp_pass, v.exp_fail, 1'b0});
        @(negedge Clk);
        chk("done_cycle_rv", rv8, 0);
        cyc();
        done8[v.sel] = 0;
        rslt8[v.sel] = v.rslt;
        @(negedge Clk);
        chk("settle_rv", rv8, 0);
        chk("settle_busy", busy8, 1);
        cyc();
        @(negedge Clk);
        chk("show_rv", rv8, 1);
        chk("show_busy", busy8, 0);
        start8 = 1;
        cyc(30);
        @(negedge Clk);
        chk("show_start_ignored_rv", rv8, 1);
        chk("show_start_ignored_pass", pass8, v.exp_pass);
        chk("show_start_ignored_fail", fail8, v.exp_fail);
        start8 = 0;
        cyc(30);
        ack_release8();
        chk("run_cycles", runs8, r0 + 1);
        rslt8 = 0;
    endtask

    initial begin
        int n, r0;
        tbl[0] = '{3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{3'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        cyc(3);
        @(negedge Clk);
        chk("rst_out8", {run8, disp8, busy8, rv8, pass8, fail8, to8}, 0);
        chk("rst_out6", {run6, disp6, busy6, rv6, pass6, fail6, to6}, 0);
        Reset = 0;
        cyc(5);
        foreach (tbl[i]) do_txn(tbl[i]);

        // Reset during WAIT_DONE with Start held through it
        sel8 = 3'd4;
        start8 = 1;
        wait_for(0, 60, n);
        cyc(4);
        chk("pre_reset_busy", busy8, 1);
        Reset = 1;
        cyc();
        Reset = 0;
        @(negedge Clk);
        chk("post_reset_out8", {run8, disp8, busy8, rv8, pass8, fail8, to8}, 0);
        r0 = runs8;
        cyc(40);
        @(negedge Clk);
        chk("held_start_no_run", runs8, r0);
        chk("held_start_idle", busy8, 0);
        start8 = 0;
        cyc(30);
        start8 = 1;
        wait_for(0, 60, n);
        chk("repress_run", run8, 8'h10);
        cyc();
        start8 = 0;
        done8[4] = 1;
        q8.push_back('{1'b1, 1'b0, 1'b0});
        cyc();
        done8[4] = 0;
        rslt8[4] = 1;
        cyc(3);
        ack_release8();
        rslt8 = 0;

        // Invalid select on the 6-chip instance
        sel6 = 3'd7;
        q6.push_back('{1'b0, 1'b1, 1'b0});
        start6 = 1;
        wait_for(4, 60, n);
        chk("bad_sel_no_run", runs6, 0);
        chk("bad_sel_busy", busy6, 0);
        start6 = 0;
        cyc(30);
        ack6 = 1;
        wait_for(3, 60, n);
        ack6 = 0;
        cyc(30);

        // Watchdog on the 6-chip instance (TIMEOUT_CYCLES=32), Done never raised
        sel6 = 3'd1;
        start6 = 1;
`ifdef CHIP_TIMEOUT_EN
        q6.push_back('{1'b0, 1'b1, 1'b1});
        wait_for(2, 60, n);
        start6 = 0;
        wait_for(4, 100, n);
        chk("timeout_latency", n, 33);
`else
        wait_for(2, 60, n);
        start6 = 0;
        cyc(100);
        @(negedge Clk);
        chk("no_timeout_rv", rv6, 0);
        chk("no_timeout_busy", busy6, 1);
        chk("no_timeout_flag", to6, 0);
        done6[1] = 1;
        rslt6[1] = 1;
        q6.push_back('{1'b1, 1'b0, 1'b0});
        wait_for(4, 10, n);
        done6 = 0;
`endif
        cyc(3);
        ack6 = 1;
        wait_for(3, 60, n);
        ack6 = 0;
        cyc();
        @(negedge Clk);
        chk("u6_final_idle", {busy6, rv6, pass6, fail6, to6}, 0);
        rslt6 = 0;
        chk("sb8_drained", q8.size(), 0);
        chk("sb6_drained", q6.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
